// File: rtl/sbp_pipeline_injector_if.sv
// rtl/sbp_pipeline_injector_if.sv - lookup and update request bundle for the pipeline injector
interface sbp_pipeline_injector_if #(
  parameter int STAGE_ID_BITS = 6,
  parameter int LOCATION_BITS = 11,
  parameter int RESULT_BITS   = 24
);
  logic                     lookup_valid_i;
  logic                     lookup_ready_o;
  logic [31:0]              lookup_ip_addr_i;
  logic                     upd_valid_i;
  logic                     upd_ready_o;
  logic [31:0]              upd_prefix_i;
  logic [5:0]               upd_prefix_len_i;
  logic [STAGE_ID_BITS-1:0] upd_stage_id_i;
  logic [LOCATION_BITS-1:0] upd_location_i;
  logic [RESULT_BITS-1:0]   upd_result_i;

  modport master (
    output lookup_valid_i, lookup_ip_addr_i,
    output upd_valid_i, upd_prefix_i, upd_prefix_len_i, upd_stage_id_i, upd_location_i, upd_result_i,
    input  lookup_ready_o, upd_ready_o
  );

  modport slave (
    input  lookup_valid_i, lookup_ip_addr_i,
    input  upd_valid_i, upd_prefix_i, upd_prefix_len_i, upd_stage_id_i, upd_location_i, upd_result_i,
    output lookup_ready_o, upd_ready_o
  );
endinterface

// File: rtl/sbp_pipeline_injector.sv
// rtl/sbp_pipeline_injector.sv - merges lookups and table updates into the lookup pipeline and collects its tail
module sbp_pipeline_injector #(
  parameter int STAGE_ID_BITS  = 6,
  parameter int LOCATION_BITS  = 11,
  parameter int RESULT_BITS    = 24,
  parameter int ROOT_STAGE_ID  = 1,
  parameter int PIPE_LATENCY   = 12,
  parameter int STARVE_LIMIT   = 4,
  parameter int UPD_FIFO_DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  sbp_pipeline_injector_if.slave   req,
  output logic                     update_o,
  output logic [31:0]              ip_addr_o,
  output logic [5:0]               bit_pos_o,
  output logic [STAGE_ID_BITS-1:0] stage_id_o,
  output logic [LOCATION_BITS-1:0] location_o,
  output logic [RESULT_BITS-1:0]   result_o,
  input  logic                     tail_update_i,
  input  logic [31:0]              tail_ip_addr_i,
  input  logic [RESULT_BITS-1:0]   tail_result_i,
  output logic                     res_valid_o,
  output logic [31:0]              res_ip_addr_o,
  output logic [RESULT_BITS-1:0]   res_result_o,
  output logic                     upd_done_o,
  output logic [7:0]               upd_pending_o,
  output logic                     err_o
);
  localparam int PTR_W   = $clog2(UPD_FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int STV_W   = $clog2(STARVE_LIMIT + 1);
  localparam int ENTRY_W = 32 + 6 + STAGE_ID_BITS + LOCATION_BITS + RESULT_BITS;
  localparam logic [CNT_W-1:0] FIFO_FULL  = CNT_W'(UPD_FIFO_DEPTH);
  localparam logic [STV_W-1:0] STARVE_MAX = STV_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {KIND_IDLE, KIND_LOOKUP, KIND_UPDATE} kind_e;

  logic [ENTRY_W-1:0]       fifo_mem [UPD_FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr, rd_ptr;
  logic [CNT_W-1:0]         fifo_cnt;
  logic [STV_W-1:0]         starve_cnt;
  kind_e                    head_kind;
  kind_e                    track_sr [PIPE_LATENCY];
  kind_e                    tail_kind;
  logic                     fifo_empty, fifo_full, push, pick_upd, pick_lkp, tail_mismatch;
  logic [ENTRY_W-1:0]       wr_entry, rd_entry;
  logic [31:0]              rd_prefix;
  logic [5:0]               rd_len;
  logic [STAGE_ID_BITS-1:0] rd_stage;
  logic [LOCATION_BITS-1:0] rd_loc;
  logic [RESULT_BITS-1:0]   rd_res;

  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == FIFO_FULL);
  assign push       = req.upd_valid_i && !fifo_full;
  // A waiting lookup only loses arbitration until the starve counter saturates.
  assign pick_upd   = !fifo_empty && (!req.lookup_valid_i || starve_cnt < STARVE_MAX);
  assign pick_lkp   = !pick_upd && req.lookup_valid_i;

  assign req.lookup_ready_o = pick_lkp;
  assign req.upd_ready_o    = !fifo_full;

  assign wr_entry = {req.upd_prefix_i, req.upd_prefix_len_i, req.upd_stage_id_i,
                     req.upd_location_i, req.upd_result_i};
  assign rd_entry = fifo_mem[rd_ptr];
  assign {rd_prefix, rd_len, rd_stage, rd_loc, rd_res} = rd_entry;

  // head_kind travels alongside the head registers, so the last stage lines up with tail_*_i.
  assign tail_kind     = track_sr[PIPE_LATENCY-1];
  assign tail_mismatch = (tail_kind == KIND_LOOKUP && tail_update_i) ||
                         (tail_kind == KIND_UPDATE && !tail_update_i);

  always_ff @(posedge clk) begin
    if (rst) begin
      update_o      <= 1'b0;
      ip_addr_o     <= '0;
      bit_pos_o     <= '0;
      stage_id_o    <= '0;
      location_o    <= '0;
      result_o      <= '0;
      head_kind     <= KIND_IDLE;
      for (int i = 0; i < PIPE_LATENCY; i++) track_sr[i] <= KIND_IDLE;
      res_valid_o   <= 1'b0;
      res_ip_addr_o <= '0;
      res_result_o  <= '0;
      upd_done_o    <= 1'b0;
      upd_pending_o <= '0;
      err_o         <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_cnt      <= '0;
      starve_cnt    <= '0;
    end else begin
      if (pick_upd) begin
        update_o   <= 1'b1;
        ip_addr_o  <= rd_prefix;
        bit_pos_o  <= rd_len;
        stage_id_o <= rd_stage;
        location_o <= rd_loc;
        result_o   <= rd_res;
        head_kind  <= KIND_UPDATE;
      end else if (pick_lkp) begin
        update_o   <= 1'b0;
        ip_addr_o  <= req.lookup_ip_addr_i;
        bit_pos_o  <= '0;
        stage_id_o <= STAGE_ID_BITS'(ROOT_STAGE_ID);
        location_o <= '0;
        result_o   <= '0;
        head_kind  <= KIND_LOOKUP;
      end else begin
        update_o   <= 1'b0;
        ip_addr_o  <= '0;
        bit_pos_o  <= '0;
        stage_id_o <= '0;
        location_o <= '0;
        result_o   <= '0;
        head_kind  <= KIND_IDLE;
      end

      track_sr[0] <= head_kind;
      for (int i = 1; i < PIPE_LATENCY; i++) track_sr[i] <= track_sr[i-1];

      res_valid_o <= (tail_kind == KIND_LOOKUP);
      if (tail_kind == KIND_LOOKUP) begin
        res_ip_addr_o <= tail_ip_addr_i;
        res_result_o  <= tail_result_i;
      end
      upd_done_o <= (tail_kind == KIND_UPDATE);
      if (tail_mismatch) err_o <= 1'b1;

      case ({pick_upd, upd_done_o})
        2'b10:   if (upd_pending_o != 8'hFF) upd_pending_o <= upd_pending_o + 8'd1;
        2'b01:   if (upd_pending_o != 8'h00) upd_pending_o <= upd_pending_o - 8'd1;
        default: ;
      endcase

      if (push) begin
        fifo_mem[wr_ptr] <= wr_entry;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pick_upd) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pick_upd})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: ;
      endcase

      if (pick_upd && req.lookup_valid_i) begin
        if (starve_cnt != STARVE_MAX) starve_cnt <= starve_cnt + STV_W'(1);
      end else begin
        starve_cnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_sbp_pipeline_injector.sv
// tb/tb_sbp_pipeline_injector.sv - scoreboard bench for the pipeline injector
module tb_sbp_pipeline_injector;
  localparam int SB  = 6;
  localparam int LB  = 11;
  localparam int RB  = 24;
  localparam int LAT = 12;
  localparam int SL  = 4;
  localparam int FD  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sbp_pipeline_injector_if #(.STAGE_ID_BITS(SB), .LOCATION_BITS(LB), .RESULT_BITS(RB)) rq();

  logic          update_o, res_valid_o, upd_done_o, err_o;
  logic [31:0]   ip_addr_o, res_ip_addr_o;
  logic [5:0]    bit_pos_o;
  logic [SB-1:0] stage_id_o;
  logic [LB-1:0] location_o;
  logic [RB-1:0] result_o, res_result_o, tail_result_i;
  logic [7:0]    upd_pending_o;
  logic          tail_update_i;
  logic [31:0]   tail_ip_addr_i;

  sbp_pipeline_injector #(
    .STAGE_ID_BITS(SB), .LOCATION_BITS(LB), .RESULT_BITS(RB), .ROOT_STAGE_ID(1),
    .PIPE_LATENCY(LAT), .STARVE_LIMIT(SL), .UPD_FIFO_DEPTH(FD)
  ) u_dut (
    .clk(clk), .rst(rst), .req(rq),
    .update_o(update_o), .ip_addr_o(ip_addr_o), .bit_pos_o(bit_pos_o),
    .stage_id_o(stage_id_o), .location_o(location_o), .result_o(result_o),
    .tail_update_i(tail_update_i), .tail_ip_addr_i(tail_ip_addr_i), .tail_result_i(tail_result_i),
    .res_valid_o(res_valid_o), .res_ip_addr_o(res_ip_addr_o), .res_result_o(res_result_o),
    .upd_done_o(upd_done_o), .upd_pending_o(upd_pending_o), .err_o(err_o)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pipeline stand-in: pure LAT-cycle delay; lookups of 0xDEAD0001 come back with a corrupted update flag.
  logic        pm_upd [LAT];
  logic [31:0] pm_ip  [LAT];
  always @(posedge clk) begin
    if (cyc < 2) begin
      for (int i = 0; i < LAT; i++) begin pm_upd[i] <= 1'b0; pm_ip[i] <= '0; end
    end else begin
      pm_upd[0] <= update_o;
      pm_ip[0]  <= ip_addr_o;
      for (int i = 1; i < LAT; i++) begin pm_upd[i] <= pm_upd[i-1]; pm_ip[i] <= pm_ip[i-1]; end
    end
  end

  function automatic logic [RB-1:0] model_result(input logic [31:0] a);
    return (a == 32'hC0A80001) ? 24'h012340 : (a[23:0] ^ 24'h5A5A5A);
  endfunction

  assign tail_update_i  = pm_upd[LAT-1] ^ (!pm_upd[LAT-1] && pm_ip[LAT-1] == 32'hDEAD0001);
  assign tail_ip_addr_i = pm_ip[LAT-1];
  assign tail_result_i  = pm_upd[LAT-1] ? '0 : model_result(pm_ip[LAT-1]);

  typedef struct {
    logic          upd;
    logic [31:0]   ip;
    logic [5:0]    bp;
    logic [SB-1:0] sid;
    logic [LB-1:0] loc;
    logic [RB-1:0] res;
    int            at;
  } head_t;
  typedef struct {
    logic [31:0]   ip;
    logic [RB-1:0] res;
    int            at;
  } res_t;

  head_t hq[$];
  res_t  resq[$];
  int    doneq[$];
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic head_t mk_head(input logic u, input logic [31:0] ip, input logic [5:0] bp,
                                    input logic [SB-1:0] sid, input logic [LB-1:0] loc,
                                    input logic [RB-1:0] res, input int at);
    head_t h;
    h.upd = u; h.ip = ip; h.bp = bp; h.sid = sid; h.loc = loc; h.res = res; h.at = at;
    return h;
  endfunction

  function automatic res_t mk_res(input logic [31:0] ip, input logic [RB-1:0] res, input int at);
    res_t r;
    r.ip = ip; r.res = res; r.at = at;
    return r;
  endfunction

  // Monitor: every non-idle head slot, result pulse and update completion is matched against the queues.
  always @(negedge clk) begin
    if (cyc >= 2) begin
      if (stage_id_o != '0) begin
        if (hq.size() == 0) begin
          chk("head_unexpected_slot", {32'd0, ip_addr_o}, 64'd0);
        end else begin
          head_t e;
          e = hq.pop_front();
          chk("head_update", update_o, e.upd);
          chk("head_ip", ip_addr_o, e.ip);
          chk("head_bit_pos", bit_pos_o, e.bp);
          chk("head_stage_id", stage_id_o, e.sid);
          chk("head_location", location_o, e.loc);
          chk("head_result", result_o, e.res);
          if (e.at >= 0) chk("head_cycle", cyc, e.at);
        end
      end else begin
        chk("idle_fields", {update_o, ip_addr_o, bit_pos_o, location_o, result_o}, 64'd0);
      end
      if (res_valid_o) begin
        if (resq.size() == 0) begin
          chk("res_unexpected_pulse", {32'd0, res_ip_addr_o}, 64'd0);
        end else begin
          res_t r;
          r = resq.pop_front();
          chk("res_ip", res_ip_addr_o, r.ip);
          chk("res_result", res_result_o, r.res);
          chk("res_cycle", cyc, r.at);
        end
      end
      if (upd_done_o) begin
        if (doneq.size() == 0) chk("upd_done_unexpected", 1, 0);
        else void'(doneq.pop_front());
      end
    end
  end

  logic [31:0] la [3] = '{32'h0B000001, 32'h0B000002, 32'h0B000003};
  logic [RB-1:0] lr [3] = '{24'h5A5A5B, 24'h5A5A58, 24'h5A5A59};

  initial begin
    int li, ui, c, hit;
    bit saw_full;
    rq.lookup_valid_i = 1'b0; rq.lookup_ip_addr_i = '0;
    rq.upd_valid_i = 1'b0; rq.upd_prefix_i = '0; rq.upd_prefix_len_i = '0;
    rq.upd_stage_id_i = '0; rq.upd_location_i = '0; rq.upd_result_i = '0;

    repeat (4) @(negedge clk);
    chk("reset_head", {update_o, stage_id_o, ip_addr_o, bit_pos_o}, 64'd0);
    chk("reset_res_done", {res_valid_o, upd_done_o, upd_pending_o, err_o}, 64'd0);
    chk("reset_upd_ready", rq.upd_ready_o, 1);
    rst = 1'b0;

    // Idle pipeline.
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("idle_stage_id", stage_id_o, 0);
    end

    // Single lookup.
    @(negedge clk);
    rq.lookup_valid_i = 1'b1; rq.lookup_ip_addr_i = 32'hC0A80001;
    #1;
    chk("lookup_ready", rq.lookup_ready_o, 1);
    hq.push_back(mk_head(1'b0, 32'hC0A80001, 6'd0, 6'd1, '0, '0, cyc + 1));
    resq.push_back(mk_res(32'hC0A80001, 24'h012340, cyc + LAT + 2));
    @(negedge clk);
    rq.lookup_valid_i = 1'b0;
    repeat (LAT + 4) @(negedge clk);

    // Single update.
    rq.upd_valid_i = 1'b1; rq.upd_prefix_i = 32'h0A000000; rq.upd_prefix_len_i = 6'd8;
    rq.upd_stage_id_i = 6'd3; rq.upd_location_i = 11'd5; rq.upd_result_i = 24'h00ABCD;
    #1;
    chk("upd_ready_empty", rq.upd_ready_o, 1);
    hq.push_back(mk_head(1'b1, 32'h0A000000, 6'd8, 6'd3, 11'd5, 24'h00ABCD, -1));
    doneq.push_back(1);
    @(negedge clk);
    rq.upd_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("pending_inflight", upd_pending_o, 1);
    hit = 0;
    for (int k = 0; k < 40 && !hit; k++) begin
      if (upd_done_o) hit = 1;
      else @(negedge clk);
    end
    chk("upd_done_seen", hit, 1);
    chk("pending_at_done", upd_pending_o, 1);
    @(negedge clk);
    chk("pending_after_done", upd_pending_o, 0);
    repeat (4) @(negedge clk);

    // Continuous lookups against six back-to-back updates: expected head order U,U,U,U,L,U,U,L,L.
    for (int i = 0; i < 4; i++)
      hq.push_back(mk_head(1'b1, 32'h10000000 + i, 6'(16 + i), 6'd2, 11'(i), 24'(12'h100 + i), -1));
    hq.push_back(mk_head(1'b0, la[0], 6'd0, 6'd1, '0, '0, -1));
    for (int i = 4; i < 6; i++)
      hq.push_back(mk_head(1'b1, 32'h10000000 + i, 6'(16 + i), 6'd2, 11'(i), 24'(12'h100 + i), -1));
    hq.push_back(mk_head(1'b0, la[1], 6'd0, 6'd1, '0, '0, -1));
    hq.push_back(mk_head(1'b0, la[2], 6'd0, 6'd1, '0, '0, -1));
    li = 0; ui = 0; saw_full = 0;
    for (int k = 0; k < 60 && !(li == 3 && ui == 6); k++) begin
      @(negedge clk);
      rq.lookup_valid_i   = (k > 0) && (li < 3);
      rq.lookup_ip_addr_i = (li < 3) ? la[li] : 32'h0;
      rq.upd_valid_i      = (ui < 6);
      rq.upd_prefix_i     = 32'h10000000 + ui;
      rq.upd_prefix_len_i = 6'(16 + ui);
      rq.upd_stage_id_i   = 6'd2;
      rq.upd_location_i   = 11'(ui);
      rq.upd_result_i     = 24'(12'h100 + ui);
      #1;
      if (!rq.upd_ready_o) saw_full = 1;
      if (rq.lookup_valid_i && rq.lookup_ready_o) begin
        resq.push_back(mk_res(la[li], lr[li], cyc + LAT + 2));
        li++;
      end
      if (rq.upd_valid_i && rq.upd_ready_o) begin
        doneq.push_back(1);
        ui++;
      end
    end
    @(negedge clk);
    rq.lookup_valid_i = 1'b0; rq.upd_valid_i = 1'b0;
    chk("starve_lookups_sent", li, 3);
    chk("starve_updates_sent", ui, 6);
    chk("upd_ready_dropped_when_full", saw_full, 1);
    repeat (LAT + 6) @(negedge clk);
    chk("starve_pending_drained", upd_pending_o, 0);

    // Tail flags an update in a lookup-tracked slot.
    rq.lookup_valid_i = 1'b1; rq.lookup_ip_addr_i = 32'hDEAD0001;
    #1;
    hq.push_back(mk_head(1'b0, 32'hDEAD0001, 6'd0, 6'd1, '0, '0, cyc + 1));
    resq.push_back(mk_res(32'hDEAD0001, 24'hF75A5B, cyc + LAT + 2));
    c = cyc;
    @(negedge clk);
    rq.lookup_valid_i = 1'b0;
    chk("err_before", err_o, 0);
    hit = -1;
    for (int k = 0; k < 40 && hit < 0; k++) begin
      if (err_o) hit = cyc;
      else @(negedge clk);
    end
    chk("err_rise_cycle", hit, c + LAT + 2);
    repeat (5) @(negedge clk);
    chk("err_sticky", err_o, 1);

    // Reset with three lookups in flight.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rq.lookup_valid_i = 1'b1; rq.lookup_ip_addr_i = 32'h0C000001 + i;
      #1;
      chk("flight_lookup_ready", rq.lookup_ready_o, 1);
      hq.push_back(mk_head(1'b0, 32'h0C000001 + i, 6'd0, 6'd1, '0, '0, cyc + 1));
    end
    @(negedge clk);
    rq.lookup_valid_i = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("midreset_head", {update_o, stage_id_o, ip_addr_o, bit_pos_o}, 64'd0);
    chk("midreset_res_done", {res_valid_o, upd_done_o, upd_pending_o, err_o}, 64'd0);
    rst = 1'b0;
    repeat (LAT + 6) @(negedge clk);

    chk("head_queue_empty", hq.size(), 0);
    chk("res_queue_empty", resq.size(), 0);
    chk("done_queue_empty", doneq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
